// File: rtl/shift_reg_univ_if.sv
// shift_reg_univ_if: mode/data/serial inputs and Q/Qn/SO outputs of the universal shift register
interface shift_reg_univ_if #(parameter int W = 8);
    logic [1:0]   S;
    logic [W-1:0] D;
    logic         DSU;
    logic         DSD;
    logic         RO;
    logic [W-1:0] Q;
    logic [W-1:0] Qn;
    logic         SO;
    modport master (output S, D, DSU, DSD, RO, input Q, Qn, SO);
    modport slave  (input S, D, DSU, DSD, RO, output Q, Qn, SO);
endinterface

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: W-bit hold/shift-up/shift-down/load register with Qn and SO; SHIFT_REG_UNIV_ROTATE_EN adds RO-driven rotate
module shift_reg_univ #(
    parameter int           W    = 8,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic           C,
    input  logic           R,
    shift_reg_univ_if.slave bus
);
    logic [W-1:0] q;
    logic [W-1:0] q_nxt;
    logic         so;
    logic         so_nxt;
    logic         in_up;
    logic         in_dn;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    assign in_up = bus.RO ? q[W-1] : bus.DSU;
    assign in_dn = bus.RO ? q[0] : bus.DSD;
`else
    logic unused_ro;
    assign unused_ro = bus.RO;
    assign in_up = bus.DSU;
    assign in_dn = bus.DSD;
`endif
    always_comb begin
        q_nxt  = bus.S == 2'b11 ? bus.D :
                 bus.S == 2'b01 ? {q[W-2:0], in_up} :
                 bus.S == 2'b10 ? {in_dn, q[W-1:1]} : q;
        so_nxt = bus.S == 2'b01 ? q[W-1] :
                 bus.S == 2'b10 ? q[0] : so;
    end
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            q  <= INIT;
            so <= 1'b0;
        end else begin
            q  <= q_nxt;
            so <= so_nxt;
        end
    end
    assign bus.Q  = q;
    assign bus.Qn = ~q;
    assign bus.SO = so;
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: directed and random stimulus against an arithmetic model of the shift register
module tb_shift_reg_univ;
    localparam int W = 8;
    localparam int TOP = 1 << (W - 1);
    localparam int FULL = 1 << W;
    logic C = 1'b0;
    logic R = 1'b1;
    shift_reg_univ_if #(.W(W)) bus ();
    shift_reg_univ #(.W(W), .INIT('0)) dut (.C(C), .R(R), .bus(bus));
    always #5 C = ~C;
    int vectors = 0;
    int miscompares = 0;
    int mq = 0;
    int mso = 0;
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic check_all(input string tag);
        chk({tag, ".q"}, bus.Q, W'(mq));
        chk({tag, ".qn"}, bus.Qn, W'(FULL - 1 - mq));
        chk({tag, ".so"}, W'(bus.SO), W'(mso));
    endtask
    // Model: shifting is multiply/divide by two with the serial bit added at the fill end
    task automatic model(input int s, input int d, input int dsu, input int dsd, input int ro);
        int rot;
        int fb;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        rot = ro;
`else
        rot = 0 * ro;
`endif
        if (s == 3) mq = d;
        else if (s == 1) begin
            fb = rot != 0 ? mq / TOP : dsu;
            mso = mq / TOP;
            mq = (mq * 2) % FULL + fb;
        end else if (s == 2) begin
            fb = rot != 0 ? mq % 2 : dsd;
            mso = mq % 2;
            mq = mq / 2 + fb * TOP;
        end
    endtask
    task automatic step(input logic [1:0] s, input logic [W-1:0] d, input logic dsu, input logic dsd, input logic ro);
        bus.S = s;
        bus.D = d;
        bus.DSU = dsu;
        bus.DSD = dsd;
        bus.RO = ro;
        @(posedge C);
        model(int'(s), int'(d), int'(dsu), int'(dsd), int'(ro));
        #1;
    endtask
    task automatic async_reset(input string tag);
        #2 R = 1'b1;
        #1;
        mq = 0;
        mso = 0;
        check_all(tag);
    endtask
    logic [7:0] up_seq;
    initial begin
        bus.S = 2'b00; bus.D = '0; bus.DSU = 0; bus.DSD = 0; bus.RO = 0;
        #12 R = 1'b0;
        step(2'b11, 8'h5A, 0, 0, 0);
        step(2'b01, 8'h00, 1, 0, 0);
        async_reset("rst_async");
        chk("rst_q_const", bus.Q, 8'h00);
        chk("rst_qn_const", bus.Qn, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 8'hFF, 1, 1, 0);
            mq = 0; mso = 0;
            check_all("rst_hold");
        end
        @(negedge C) R = 1'b0;
        step(2'b11, 8'hA5, 0, 0, 0);
        check_all("load");
        chk("load_const", bus.Q, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 8'h3C, 1, 1, 1);
            check_all("hold");
        end
        step(2'b11, 8'h00, 0, 0, 0);
        up_seq = 8'b10110010;
        for (int i = 7; i >= 0; i--) step(2'b01, 8'hFF, up_seq[i], 1, 0);
        check_all("up8");
        chk("up8_const", bus.Q, 8'hB2);
        step(2'b01, 8'h00, 0, 1, 0);
        check_all("up9");
        chk("up9_const", bus.Q, 8'h64);
        step(2'b11, 8'h81, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(2'b10, 8'hFF, 1, 0, 0);
            check_all($sformatf("drain%0d", i));
        end
        chk("drain_const", bus.Q, 8'h00);
        @(negedge C) R = 1'b0;
        step(2'b01, 8'h00, 1, 0, 0);
        step(2'b01, 8'h00, 1, 0, 0);
        async_reset("rst_mid");
        @(negedge C) R = 1'b0;
        step(2'b01, 8'h00, 1, 0, 0);
        check_all("rst_release");
        step(2'b11, 8'h81, 0, 0, 0);
        step(2'b01, 8'h00, 0, 0, 1);
        check_all("rot_up");
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        chk("rot_const", bus.Q, 8'h03);
`else
        chk("rot_const", bus.Q, 8'h02);
`endif
        step(2'b10, 8'h00, 0, 0, 1);
        check_all("rot_dn");
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            check_all("rand");
            if ($urandom_range(0, 24) == 0) begin
                async_reset("rand_rst");
                @(negedge C) R = 1'b0;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
